tt_sweep_capture: RTL and testbench
===================================

Name: tt_sweep_capture

Overview:
- Sequential truth-table extractor that sits directly upstream and downstream of a 7-input combinational function under classification.
- Drives all 2^7 input vectors onto the function, samples its single output, and assembles the 128-bit truth table.
- Hex form of the table is MSB = f(1111111), LSB = f(0000000). The same block also produces the on-set weight and an equality check against an expected table, for the classification flow.

Parameters:
NUM_INPUTS, 7, number of function inputs; NUM_VEC = 2**NUM_INPUTS
SETTLE_CYCLES, 0, extra cycles each vector is held before sampling (0..15)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a sweep; accepted only in IDLE
expected  in  NUM_VEC  reference table; latched when start is accepted
x  out  NUM_INPUTS  vector driven to the function; x[0]=x0 ... x[6]=x6; registered
f_in  in  1  function output for the current x
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse after the last sample
tt  out  NUM_VEC  captured table; bit i = f(x=i)
tt_valid  out  1  tt, ones and match are complete and stable
ones  out  NUM_INPUTS+1  popcount of tt (0..128)
match  out  1  tt == latched expected; valid while tt_valid

Behaviour:
- Reset (async, any state, including mid-sweep): state=IDLE. All of the following clear to 0: x, busy, done, tt, tt_valid, ones, match, idx, settle counter, latched expected. No partial results survive.
- States: IDLE, SETTLE, DONE.
- IDLE + start:
  - idx=0, x=0, tt=0, ones=0, tt_valid=0, match=0.
  - Latch expected; load settle count = SETTLE_CYCLES.
  - busy=1; go to SETTLE.
- SETTLE, count>0: decrement; x held.
- SETTLE, count==0 (sample edge): tt[idx] <= f_in; ones <= ones + f_in.
  - If idx==NUM_VEC-1: go to DONE.
  - Else: idx++, x <= idx+1, reload count.
- Each vector is held SETTLE_CYCLES+1 cycles. The sample edge is the last clock edge of that hold.
- With SETTLE_CYCLES=0, f_in is sampled on the first edge after x updates, so the function's combinational path must close within one cycle.
- DONE (one cycle):
  - done=1, busy=0, tt_valid=1.
  - match = (tt_final == latched expected). The compare uses the table including the final sampled bit; implement by comparing the next-state value or registering in DONE.
  - x returns to 0. Next state is IDLE.
- Latency: start edge to done-high = NUM_VEC*(SETTLE_CYCLES+1)+1 cycles. Default: 129.
- start while busy or in DONE: ignored; the sweep is unaffected.
- Changes on expected after acceptance: no effect.
- Results hold in IDLE until the next accepted start, which clears tt_valid in the same cycle.
- idx is NUM_INPUTS bits wide. Termination is by compare to NUM_VEC-1, never by wrap. ones cannot overflow (max 128 fits 8 bits).
- x/f_in is a purely combinational loop through the external function; no handshake on it.

Decomposition:
- Package tt_pkg:
  - NUM_INPUTS_DEF, NUM_VEC_DEF.
  - State enum {IDLE, SETTLE, DONE}.
  - typedef tt_t (NUM_VEC bits).
  - typedef ones_t (NUM_INPUTS+1 bits).
- One sub-module, tt_settle_timer: loadable down-counter with a zero flag. Holds the SETTLE_CYCLES hold logic separately from the sweep FSM.

Test Plan:
- f = x0, SETTLE_CYCLES=0, start pulse:
  - done exactly 129 cycles after the start edge.
  - tt=0xAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, ones=64.
- f = maj(x0,x1,x2), expected = 0xE8 repeated 16 bytes:
  - tt matches that value, ones=64, match=1.
  - Rerun with expected bit0 flipped: match=0.
- f = constant 1 and then constant 0:
  - tt all ones, ones=128, match against all-ones=1.
  - tt=0, ones=0.
- SETTLE_CYCLES=2, f = x6:
  - x changes every 3 cycles; done at cycle 385.
  - tt upper 64 bits all ones, lower 64 zero.
- start pulsed at cycles 10 and 50 of a sweep; expected changed mid-sweep:
  - Single sweep, done timing unchanged.
  - match uses the expected value latched at start.
- rst asserted asynchronously at idx=37 mid-cycle:
  - Outputs zero immediately, busy=0.
  - A fresh start then completes normally with correct tt.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types for the truth-table sweep: FSM states, table and popcount widths.
package tt_pkg;
   localparam int NUM_INPUTS_DEF = 7;
   localparam int NUM_VEC_DEF    = 2 ** NUM_INPUTS_DEF;

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   typedef logic [NUM_VEC_DEF-1:0]  tt_t;
   typedef logic [NUM_INPUTS_DEF:0] ones_t;
endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that marks the last cycle of a vector hold; load wins over count.
// Zero flag is combinational from the count register; no backpressure.
module tt_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);
   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);
endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps every input vector through an external function and captures its truth table.
// start-to-done is NUM_VEC*(SETTLE_CYCLES+1)+1 cycles; start is ignored unless idle.
module tt_sweep_capture
   import tt_pkg::*;
#(
   parameter int NUM_INPUTS    = NUM_INPUTS_DEF,
   parameter int SETTLE_CYCLES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [2**NUM_INPUTS-1:0] expected,
   output logic [NUM_INPUTS-1:0]   x,
   input  logic                    f_in,
   output logic                    busy,
   output logic                    done,
   output logic [2**NUM_INPUTS-1:0] tt,
   output logic                    tt_valid,
   output logic [NUM_INPUTS:0]     ones,
   output logic                    match
);
   localparam int NUM_VEC = 2 ** NUM_INPUTS;
   localparam logic [NUM_INPUTS-1:0] IDX_LAST  = '1;
   localparam logic [3:0]            SETTLE_LD = 4'(SETTLE_CYCLES);

   state_t                  state, state_n;
   logic [NUM_INPUTS-1:0]   idx, idx_n, x_n;
   logic [NUM_VEC-1:0]      tt_n, exp_q, exp_n;
   logic [NUM_INPUTS:0]     ones_n;
   logic                    busy_n, done_n, tt_valid_n, match_n;
   logic                    settle_load, settle_zero;

   tt_settle_timer #(.W(4)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (settle_load),
      .load_val (SETTLE_LD),
      .en       (state == SETTLE),
      .zero     (settle_zero)
   );

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      x_n         = x;
      tt_n        = tt;
      ones_n      = ones;
      exp_n       = exp_q;
      busy_n      = busy;
      done_n      = 1'b0;
      tt_valid_n  = tt_valid;
      match_n     = match;
      settle_load = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n     = SETTLE;
               idx_n       = '0;
               x_n         = '0;
               tt_n        = '0;
               ones_n      = '0;
               tt_valid_n  = 1'b0;
               match_n     = 1'b0;
               exp_n       = expected;
               busy_n      = 1'b1;
               settle_load = 1'b1;
            end
         end
         SETTLE: begin
            // Sample edge: the last edge of this vector's hold.
            if (settle_zero) begin
               tt_n[idx] = f_in;
               ones_n    = ones + (NUM_INPUTS+1)'(f_in);
               if (idx == IDX_LAST) begin
                  state_n = DONE;
               end else begin
                  idx_n       = idx + NUM_INPUTS'(1);
                  x_n         = idx + NUM_INPUTS'(1);
                  settle_load = 1'b1;
               end
            end
         end
         DONE: begin
            // tt already holds the final sample here, so the compare sees the full table.
            done_n     = 1'b1;
            busy_n     = 1'b0;
            tt_valid_n = 1'b1;
            match_n    = (tt == exp_q);
            x_n        = '0;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         x        <= '0;
         tt       <= '0;
         ones     <= '0;
         exp_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tt_valid <= 1'b0;
         match    <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         x        <= x_n;
         tt       <= tt_n;
         ones     <= ones_n;
         exp_q    <= exp_n;
         busy     <= busy_n;
         done     <= done_n;
         tt_valid <= tt_valid_n;
         match    <= match_n;
      end
   end
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench: table of functions on a SETTLE_CYCLES=0 instance plus hand sequences
// for ignored starts, async reset mid-sweep and a SETTLE_CYCLES=2 instance.
module tb_tt_sweep_capture;
   import tt_pkg::*;

   localparam int M_X0 = 0, M_MAJ = 1, M_ONE = 2, M_ZERO = 3, M_X6 = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int   fmode;
   logic start0, start2;
   tt_t  exp0, exp2, tt0, tt2;
   logic [6:0] x0, x2;
   logic f0, f2;
   logic busy0, busy2, done0, done2, ttv0, ttv2, match0, match2;
   ones_t ones0, ones2;

   function automatic logic fn(input int m, input logic [6:0] v);
      case (m)
         M_X0:    return v[0];
         M_MAJ:   return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
         M_ONE:   return 1'b1;
         M_ZERO:  return 1'b0;
         default: return v[6];
      endcase
   endfunction

   assign f0 = fn(fmode, x0);
   assign f2 = fn(fmode, x2);

   tt_sweep_capture #(.NUM_INPUTS(7), .SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .expected(exp0), .x(x0), .f_in(f0),
      .busy(busy0), .done(done0), .tt(tt0), .tt_valid(ttv0), .ones(ones0), .match(match0)
   );

   tt_sweep_capture #(.NUM_INPUTS(7), .SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .expected(exp2), .x(x2), .f_in(f2),
      .busy(busy2), .done(done2), .tt(tt2), .tt_valid(ttv2), .ones(ones2), .match(match2)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Starts a sweep on instance 0 or 2; returns edges from accept to done and x after edges 2 and 3.
   task automatic sweep(input int which, output int lat, output logic [6:0] xa, output logic [6:0] xb);
      @(negedge clk);
      if (which == 0) start0 = 1'b1; else start2 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start2 = 1'b0;
      check("accept_busy",     128'((which == 0) ? busy0 : busy2), 128'd1);
      check("accept_tt_valid", 128'((which == 0) ? ttv0 : ttv2), 128'd0);
      lat = 0;
      xa  = '0;
      xb  = '0;
      while (!((which == 0) ? done0 : done2) && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 2) xa = (which == 0) ? x0 : x2;
         if (lat == 3) xb = (which == 0) ? x0 : x2;
      end
   endtask

   typedef struct {
      int    mode;
      tt_t   expv;
      tt_t   tt;
      ones_t ones;
      logic  match;
   } vec_t;

   vec_t vec[5];

   initial begin
      int lat, n;
      logic [6:0] xa, xb;

      vec[0] = '{M_X0,   128'h0,                     {16{8'hAA}},  8'd64,  1'b0};
      vec[1] = '{M_MAJ,  {16{8'hE8}},                {16{8'hE8}},  8'd64,  1'b1};
      vec[2] = '{M_MAJ,  {16{8'hE8}} ^ 128'h1,       {16{8'hE8}},  8'd64,  1'b0};
      vec[3] = '{M_ZERO, 128'h0,                     128'h0,       8'd0,   1'b1};
      vec[4] = '{M_ONE,  {128{1'b1}},                {128{1'b1}},  8'd128, 1'b1};

      rst = 1'b1; start0 = 1'b0; start2 = 1'b0; exp0 = '0; exp2 = '0; fmode = M_X0;
      #12;
      check("rst_x",      128'(x0),    128'd0);
      check("rst_busy",   128'(busy0), 128'd0);
      check("rst_done",   128'(done0), 128'd0);
      check("rst_tt",     tt0,         128'd0);
      check("rst_valid",  128'(ttv0),  128'd0);
      check("rst_ones",   128'(ones0), 128'd0);
      check("rst_match",  128'(match0), 128'd0);
      check("rst_x2",     128'(x2),    128'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         fmode = vec[i].mode;
         exp0  = vec[i].expv;
         sweep(0, lat, xa, xb);
         check($sformatf("v%0d_latency", i), 128'(lat),    128'd129);
         check($sformatf("v%0d_x_step", i),  128'(xa),     128'd2);
         check($sformatf("v%0d_tt", i),      tt0,          vec[i].tt);
         check($sformatf("v%0d_ones", i),    128'(ones0),  128'(vec[i].ones));
         check($sformatf("v%0d_match", i),   128'(match0), 128'(vec[i].match));
         check($sformatf("v%0d_valid", i),   128'(ttv0),   128'd1);
         check($sformatf("v%0d_busy", i),    128'(busy0),  128'd0);
         @(posedge clk); #1;
         check($sformatf("v%0d_done_pulse", i), 128'(done0), 128'd0);
         check($sformatf("v%0d_hold_tt", i),    tt0,         vec[i].tt);
         check($sformatf("v%0d_hold_valid", i), 128'(ttv0),  128'd1);
      end

      // Extra starts and a changed reference during a sweep must not disturb it.
      fmode = M_MAJ;
      exp0  = {16{8'hE8}};
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (!done0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
         start0 = (n == 10 || n == 50) ? 1'b1 : 1'b0;
         if (n == 20) exp0 = ~exp0;
      end
      check("ignore_latency", 128'(n),      128'd129);
      check("ignore_match",   128'(match0), 128'd1);
      check("ignore_tt",      tt0,          {16{8'hE8}});
      @(posedge clk); #1;
      check("ignore_no_restart", 128'(busy0), 128'd0);

      // Async reset in the middle of the hold of vector 37.
      fmode = M_ONE;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n = 0;
      while (x0 != 7'd37 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_idx37", 128'(n), 128'd37);
      #2 rst = 1'b1;
      #1;
      check("arst_x",     128'(x0),    128'd0);
      check("arst_busy",  128'(busy0), 128'd0);
      check("arst_tt",    tt0,         128'd0);
      check("arst_ones",  128'(ones0), 128'd0);
      check("arst_valid", 128'(ttv0),  128'd0);
      @(negedge clk);
      rst = 1'b0;
      fmode = M_X0;
      exp0  = {16{8'hAA}};
      sweep(0, lat, xa, xb);
      check("post_rst_latency", 128'(lat),    128'd129);
      check("post_rst_tt",      tt0,          {16{8'hAA}});
      check("post_rst_match",   128'(match0), 128'd1);

      // Three-cycle hold per vector.
      fmode = M_X6;
      exp2  = {{64{1'b1}}, {64{1'b0}}};
      sweep(2, lat, xa, xb);
      check("s2_latency", 128'(lat),    128'd385);
      check("s2_x_held",  128'(xa),     128'd0);
      check("s2_x_step",  128'(xb),     128'd1);
      check("s2_tt",      tt2,          {{64{1'b1}}, {64{1'b0}}});
      check("s2_ones",    128'(ones2),  128'd64);
      check("s2_match",   128'(match2), 128'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
